// File: rtl/herring_bus_pkg.sv
// Shared types, default memory map and field helpers for the Herring bus controller.
package herring_bus_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    HIGH    = 2'd1,
    STRETCH = 2'd2
  } phase_t;

  localparam int HB_NUM_CS       = 8;
  localparam int HB_WS_W         = 4;
  localparam int HB_DEFAULT_HALF = 512;

  // Widest chip-select table the field extractor accepts.
  localparam int MAX_CS = 32;

  // ACIA at 0x8000 (region 6), VIA at 0x8400 (region 5); every other region disabled.
  localparam logic [HB_NUM_CS*6-1:0]       HB_CS_BASE = {6'h00, 6'h20, 6'h21, 30'h0};
  localparam logic [HB_NUM_CS*6-1:0]       HB_CS_MASK = {6'h00, 6'h3F, 6'h3F, 30'h0};
  localparam logic [HB_NUM_CS*HB_WS_W-1:0] HB_CS_WAIT = '0;

  typedef struct packed {
    logic [5:0] base;
    logic [5:0] mask;
  } region_t;

  function automatic region_t region_fields(
    input logic [MAX_CS*6-1:0] base_vec,
    input logic [MAX_CS*6-1:0] mask_vec,
    input int                  idx
  );
    region_t r;
    r.base = base_vec[6*idx +: 6];
    r.mask = mask_vec[6*idx +: 6];
    return r;
  endfunction

endpackage

// File: rtl/herring_cs_decode.sv
// Combinational priority decode of address[15:10] into active-low chip selects
// plus the wait-state count of the winning region.
module herring_cs_decode
  import herring_bus_pkg::*;
#(
  parameter int                         NUM_CS  = HB_NUM_CS,
  parameter int                         WS_W    = HB_WS_W,
  parameter logic [NUM_CS*6-1:0]        CS_BASE = HB_CS_BASE,
  parameter logic [NUM_CS*6-1:0]        CS_MASK = HB_CS_MASK,
  parameter logic [NUM_CS*WS_W-1:0]     CS_WAIT = HB_CS_WAIT
) (
  input  logic [5:0]        address,
  output logic [NUM_CS-1:0] cs_n,
  output logic [WS_W-1:0]   wait_sel
);

  localparam logic [MAX_CS*6-1:0] BASE_EXT = (MAX_CS*6)'(CS_BASE);
  localparam logic [MAX_CS*6-1:0] MASK_EXT = (MAX_CS*6)'(CS_MASK);

  region_t region;
  logic    found;

  // Lowest index wins; an all-zero mask means the region is unused.
  always_comb begin
    cs_n     = '1;
    wait_sel = '0;
    found    = 1'b0;
    region   = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      region = region_fields(BASE_EXT, MASK_EXT, i);
      if (!found && (region.mask != 6'd0) &&
          ((address & region.mask) == (region.base & region.mask))) begin
        found    = 1'b1;
        cs_n[i]  = 1'b0;
        wait_sel = CS_WAIT[i*WS_W +: WS_W];
      end
    end
  end

endmodule

// File: rtl/herring_bus_ctrl.sv
// Herring bus controller: programmable 65C02 clock with per-region wait-state stretching and chip-select decode.
// Optional single-step control is built when HERRING_BUS_STEP_EN is defined.
module herring_bus_ctrl
  import herring_bus_pkg::*;
#(
  parameter int                     NUM_CS       = HB_NUM_CS,
  parameter int                     DIV_W        = 16,
  parameter int                     DEFAULT_HALF = HB_DEFAULT_HALF,
  parameter int                     WS_W         = HB_WS_W,
  parameter logic [NUM_CS*6-1:0]    CS_BASE      = HB_CS_BASE,
  parameter logic [NUM_CS*6-1:0]    CS_MASK      = HB_CS_MASK,
  parameter logic [NUM_CS*WS_W-1:0] CS_WAIT      = HB_CS_WAIT
) (
  input  logic              clk_src,
  input  logic              rst_n,
  input  logic [5:0]        address,
  input  logic              rw,
  input  logic              cpu_clk_out,
  input  logic [DIV_W-1:0]  div_half,
  input  logic              div_load,
`ifdef HERRING_BUS_STEP_EN
  input  logic              step,
  input  logic              step_mode,
`endif
  output logic              cpu_clk_in,
  output logic [NUM_CS-1:0] cs_n,
  output logic              we_n,
  output logic              stretching
);

  localparam logic [DIV_W-1:0] RESET_HALF = DIV_W'(DEFAULT_HALF);

  phase_t            state;
  phase_t            state_next;
  logic [DIV_W-1:0]  count;
  logic [DIV_W-1:0]  count_next;
  logic [DIV_W-1:0]  half_active;
  logic [DIV_W-1:0]  half_active_next;
  logic [DIV_W-1:0]  half_pending;
  logic [DIV_W-1:0]  load_value;
  logic [DIV_W-1:0]  half_last;
  logic [WS_W-1:0]   wait_count;
  logic [WS_W-1:0]   wait_next;
  logic [WS_W-1:0]   wait_sel;
  logic [NUM_CS-1:0] decode_cs_n;
  logic              phase_done;
  logic              advance;

  herring_cs_decode #(
    .NUM_CS  (NUM_CS),
    .WS_W    (WS_W),
    .CS_BASE (CS_BASE),
    .CS_MASK (CS_MASK),
    .CS_WAIT (CS_WAIT)
  ) u_decode (
    .address  (address),
    .cs_n     (decode_cs_n),
    .wait_sel (wait_sel)
  );

  assign cs_n       = rst_n ? decode_cs_n : '1;
  assign we_n       = ~(cpu_clk_out & ~rw);
  assign load_value = (div_half == '0) ? DIV_W'(1) : div_half;
  assign half_last  = half_active - DIV_W'(1);
  assign phase_done = (count == half_last);

`ifdef HERRING_BUS_STEP_EN
  // In step mode the clock parks at the end of LOW until a step pulse releases one cycle.
  assign advance = !step_mode || step;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    state_next       = state;
    count_next       = count + DIV_W'(1);
    wait_next        = wait_count;
    half_active_next = half_active;
    unique case (state)
      LOW: begin
        if (phase_done) begin
          if (advance) begin
            state_next = HIGH;
            count_next = '0;
            wait_next  = wait_sel;
          end else begin
            count_next = count;
          end
        end
      end
      HIGH: begin
        if (phase_done) begin
          count_next = '0;
          state_next = (wait_count == '0) ? LOW : STRETCH;
        end
      end
      STRETCH: begin
        if (phase_done) begin
          count_next = '0;
          wait_next  = wait_count - WS_W'(1);
          if (wait_count == WS_W'(1)) state_next = LOW;
        end
      end
      default: begin
        state_next = LOW;
        count_next = '0;
      end
    endcase
    // A divisor loaded on the LOW-entry edge applies to that LOW phase.
    if ((state_next == LOW) && (state != LOW))
      half_active_next = div_load ? load_value : half_pending;
  end

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOW;
      count        <= '0;
      wait_count   <= '0;
      half_active  <= RESET_HALF;
      half_pending <= RESET_HALF;
      cpu_clk_in   <= 1'b0;
      stretching   <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      wait_count   <= wait_next;
      half_active  <= half_active_next;
      if (div_load) half_pending <= load_value;
      cpu_clk_in   <= (state_next != LOW);
      stretching   <= (state_next == STRETCH);
    end
  end

endmodule

// File: tb/tb_herring_bus_ctrl.sv
// Scoreboard bench for herring_bus_ctrl: expected phase lengths and decodes are queued
// when stimulus is applied and compared when the DUT produces them.
`timescale 1ns/1ps
module tb_herring_bus_ctrl;

  localparam int NUM_CS = 8;
  localparam int DIV_W  = 16;
  localparam int WS_W   = 4;
  localparam int LIMIT  = 3000;

  // Regions 5/6 keep the production ACIA/VIA map; regions 0 and 3 overlap at 0x3F;
  // region 7 has base 0 but a zero mask, so it must never match.
  localparam logic [47:0] TB_BASE = {6'h00, 6'h20, 6'h21, 6'h00, 6'h3F, 6'h00, 6'h00, 6'h3C};
  localparam logic [47:0] TB_MASK = {6'h00, 6'h3F, 6'h3F, 6'h00, 6'h3F, 6'h00, 6'h00, 6'h3C};
  localparam logic [31:0] TB_WAIT = 32'h0000_5002;

  logic             clk_src     = 1'b0;
  logic             rst_n       = 1'b0;
  logic [5:0]       address     = 6'h00;
  logic             rw          = 1'b1;
  logic             cpu_clk_out = 1'b0;
  logic [DIV_W-1:0] div_half    = '0;
  logic             div_load    = 1'b0;
  logic             cpu_clk_in;
  logic [NUM_CS-1:0] cs_n;
  logic             we_n;
  logic             stretching;
`ifdef HERRING_BUS_STEP_EN
  logic             step        = 1'b0;
  logic             step_mode   = 1'b0;
`endif

  typedef struct {
    string name;
    logic  level;
    int    len;
    int    stretch;
  } phase_exp_t;

  typedef struct {
    logic [5:0]        addr;
    logic [NUM_CS-1:0] cs;
  } dec_exp_t;

  phase_exp_t phase_q[$];
  dec_exp_t   dec_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  herring_bus_ctrl #(
    .NUM_CS       (NUM_CS),
    .DIV_W        (DIV_W),
    .DEFAULT_HALF (512),
    .WS_W         (WS_W),
    .CS_BASE      (TB_BASE),
    .CS_MASK      (TB_MASK),
    .CS_WAIT      (TB_WAIT)
  ) dut (
    .clk_src     (clk_src),
    .rst_n       (rst_n),
    .address     (address),
    .rw          (rw),
    .cpu_clk_out (cpu_clk_out),
    .div_half    (div_half),
    .div_load    (div_load),
`ifdef HERRING_BUS_STEP_EN
    .step        (step),
    .step_mode   (step_mode),
`endif
    .cpu_clk_in  (cpu_clk_in),
    .cs_n        (cs_n),
    .we_n        (we_n),
    .stretching  (stretching)
  );

  always #5 clk_src = ~clk_src;

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts negedge samples while cpu_clk_in stays at level, starting with the current sample.
  task automatic measure(input logic level, output int len, output int stretch);
    len     = 0;
    stretch = 0;
    while (cpu_clk_in === level && len < LIMIT) begin
      len++;
      if (stretching === 1'b1) stretch++;
      @(negedge clk_src);
    end
  endtask

  task automatic push_phase(input string name, input logic level, input int len, input int stretch);
    phase_exp_t e;
    e.name    = name;
    e.level   = level;
    e.len     = len;
    e.stretch = stretch;
    phase_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    address = 6'h21;
    repeat (3) @(negedge clk_src);
    tests_run++;
    if (cpu_clk_in !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_clk: got %b, expected 0", cpu_clk_in);
    end
    tests_run++;
    if (stretching !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stretching: got %b, expected 0", stretching);
    end
    tests_run++;
    if (cs_n !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL reset_cs_n: got %b, expected 11111111", cs_n);
    end
    address = 6'h00;
    rst_n   = 1'b1;
  endtask

  task automatic test_default_period();
    phase_exp_t e;
    int len, st;
    push_phase("default_low_first", 1'b0, 512, 0);
    push_phase("default_high", 1'b1, 512, 0);
    push_phase("default_low", 1'b0, 512, 0);
    push_phase("default_high2", 1'b1, 512, 0);
    while (phase_q.size() > 0) begin
      e = phase_q.pop_front();
      measure(e.level, len, st);
      tests_run++;
      if (len !== e.len || st !== e.stretch) begin
        tests_failed++;
        $display("[TB] FAIL %s: got %0d cycles (%0d stretching), expected %0d (%0d stretching)",
                 e.name, len, st, e.len, e.stretch);
      end
    end
  endtask

  task automatic test_decode();
    logic [5:0]        addrs[8];
    logic [NUM_CS-1:0] exps[8];
    dec_exp_t d;
    addrs = '{6'h21, 6'h20, 6'h00, 6'h3F, 6'h3C, 6'h3E, 6'h1F, 6'h3B};
    exps  = '{8'b1101_1111, 8'b1011_1111, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      address = addrs[i];
      d.addr  = addrs[i];
      d.cs    = exps[i];
      dec_q.push_back(d);
      #1;
      d = dec_q.pop_front();
      tests_run++;
      if (cs_n !== d.cs) begin
        tests_failed++;
        $display("[TB] FAIL decode_%h: got %b, expected %b", d.addr, cs_n, d.cs);
      end
      @(negedge clk_src);
    end
    address = 6'h00;
  endtask

  task automatic test_we_n();
    logic clk_v[4];
    logic rw_v[4];
    logic exp_v[4];
    clk_v = '{1'b0, 1'b0, 1'b1, 1'b1};
    rw_v  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_v = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cpu_clk_out = clk_v[i];
      rw          = rw_v[i];
      #1;
      tests_run++;
      if (we_n !== exp_v[i]) begin
        tests_failed++;
        $display("[TB] FAIL we_n_phi%b_rw%b: got %b, expected %b", clk_v[i], rw_v[i], we_n, exp_v[i]);
      end
    end
    cpu_clk_out = 1'b0;
    rw          = 1'b1;
    @(negedge clk_src);
  endtask

  task automatic test_div_load();
    phase_exp_t e;
    int len, st, n;
    n = 0;
    while (cpu_clk_in !== 1'b1 && n < LIMIT) begin
      @(negedge clk_src);
      n++;
    end
    tests_run++;
    if (cpu_clk_in !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL div_load_sync: got %b, expected 1", cpu_clk_in);
    end
    push_phase("load10_high_unchanged", 1'b1, 512, 0);
    push_phase("load10_low", 1'b0, 10, 0);
    push_phase("load10_high", 1'b1, 10, 0);
    fork
      begin
        repeat (100) @(negedge clk_src);
        div_half = 16'd10;
        div_load = 1'b1;
        @(negedge clk_src);
        div_load = 1'b0;
      end
      begin
        while (phase_q.size() > 0) begin
          e = phase_q.pop_front();
          measure(e.level, len, st);
          tests_run++;
          if (len !== e.len || st !== e.stretch) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d cycles (%0d stretching), expected %0d (%0d stretching)",
                     e.name, len, st, e.len, e.stretch);
          end
        end
      end
    join
    // Zero is clamped to one; the LOW already running keeps its 10.
    div_half = '0;
    div_load = 1'b1;
    push_phase("load0_low_running", 1'b0, 10, 0);
    push_phase("load0_high_running", 1'b1, 10, 0);
    push_phase("load0_low", 1'b0, 1, 0);
    push_phase("load0_high", 1'b1, 1, 0);
    push_phase("load0_low2", 1'b0, 1, 0);
    push_phase("load0_high2", 1'b1, 1, 0);
    fork
      begin
        @(negedge clk_src);
        div_load = 1'b0;
      end
      begin
        while (phase_q.size() > 0) begin
          e = phase_q.pop_front();
          measure(e.level, len, st);
          tests_run++;
          if (len !== e.len || st !== e.stretch) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d cycles (%0d stretching), expected %0d (%0d stretching)",
                     e.name, len, st, e.len, e.stretch);
          end
        end
      end
    join
  endtask

  task automatic test_wait_states();
    phase_exp_t e;
    int len, st;
    @(negedge clk_src);
    tests_run++;
    if (cpu_clk_in !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wait_sync: got %b, expected 1", cpu_clk_in);
    end
    // Load lands on the LOW-entry edge, so the very next LOW is already 4 long.
    div_half = 16'd4;
    div_load = 1'b1;
    address  = 6'h3C;
    @(negedge clk_src);
    div_load = 1'b0;
    push_phase("ws_low_coincident", 1'b0, 4, 0);
    push_phase("ws_high_wait2", 1'b1, 12, 8);
    push_phase("ws_low", 1'b0, 4, 0);
    push_phase("ws_high_wait2_again", 1'b1, 12, 8);
    for (int pass = 0; pass < 3; pass++) begin
      while (phase_q.size() > 0) begin
        e = phase_q.pop_front();
        measure(e.level, len, st);
        tests_run++;
        if (len !== e.len || st !== e.stretch) begin
          tests_failed++;
          $display("[TB] FAIL %s: got %0d cycles (%0d stretching), expected %0d (%0d stretching)",
                   e.name, len, st, e.len, e.stretch);
        end
      end
      if (pass == 0) begin
        address = 6'h3F;
        push_phase("ws_overlap_low", 1'b0, 4, 0);
        push_phase("ws_overlap_high_region0", 1'b1, 12, 8);
      end else if (pass == 1) begin
        address = 6'h00;
        push_phase("ws_nomatch_low", 1'b0, 4, 0);
        push_phase("ws_nomatch_high", 1'b1, 4, 0);
      end
    end
  endtask

  task automatic test_reset_mid_stretch();
    phase_exp_t e;
    int len, st, n;
    address = 6'h3C;
    n = 0;
    while (stretching !== 1'b1 && n < 100) begin
      @(negedge clk_src);
      n++;
    end
    tests_run++;
    if (stretching !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_reach_stretch: got %b, expected 1", stretching);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (cpu_clk_in !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_async_clk: got %b, expected 0", cpu_clk_in);
    end
    tests_run++;
    if (stretching !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_async_stretching: got %b, expected 0", stretching);
    end
    @(negedge clk_src);
    tests_run++;
    if (cs_n !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL rst_cs_forced: got %b, expected 11111111", cs_n);
    end
    address = 6'h00;
    rst_n   = 1'b1;
    push_phase("rst_low_default", 1'b0, 512, 0);
    push_phase("rst_high_default", 1'b1, 512, 0);
    while (phase_q.size() > 0) begin
      e = phase_q.pop_front();
      measure(e.level, len, st);
      tests_run++;
      if (len !== e.len || st !== e.stretch) begin
        tests_failed++;
        $display("[TB] FAIL %s: got %0d cycles (%0d stretching), expected %0d (%0d stretching)",
                 e.name, len, st, e.len, e.stretch);
      end
    end
  endtask

`ifdef HERRING_BUS_STEP_EN
  task automatic test_step();
    int rises, highs;
    logic prev;
    step_mode = 1'b1;
    div_half  = 16'd4;
    div_load  = 1'b1;
    @(negedge clk_src);
    div_load = 1'b0;
    repeat (600) @(negedge clk_src);
    rises = 0;
    prev  = cpu_clk_in;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_src);
      if (cpu_clk_in && !prev) rises++;
      prev = cpu_clk_in;
    end
    tests_run++;
    if (rises !== 0 || cpu_clk_in !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL step_hold: got %0d rises, clk %b, expected 0 rises, clk 0", rises, cpu_clk_in);
    end
    // Second pulse lands mid-HIGH and must be ignored.
    rises = 0;
    highs = 0;
    prev  = cpu_clk_in;
    step  = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk_src);
      if (i == 0)   step = 1'b0;
      if (i == 100) step = 1'b1;
      if (i == 101) step = 1'b0;
      if (cpu_clk_in && !prev) rises++;
      if (cpu_clk_in) highs++;
      prev = cpu_clk_in;
    end
    tests_run++;
    if (rises !== 1 || highs !== 512) begin
      tests_failed++;
      $display("[TB] FAIL step_single: got %0d rises, %0d high cycles, expected 1 rise, 512 high cycles",
               rises, highs);
    end
    step_mode = 1'b0;
  endtask
`endif

  initial begin
    @(negedge clk_src);
    test_reset();
    test_default_period();
    test_decode();
    test_we_n();
    test_div_load();
    test_wait_states();
    test_reset_mid_stretch();
`ifdef HERRING_BUS_STEP_EN
    test_step();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
